// File: rtl/display_pkg.sv
// Shared constants and types for the on-chip display link model.
package display_pkg;

  localparam int DEF_COLS  = 128;
  localparam int DEF_PAGES = 8;
  localparam int COL_W     = $clog2(DEF_COLS);
  localparam int PAGE_W    = $clog2(DEF_PAGES);

  typedef logic [PAGE_W-1:0] page_t;
  typedef logic [COL_W-1:0]  col_t;

  // Opcode prefixes for the optional address commands.
  localparam logic [3:0] CMD_COL_LO = 4'h0;     // 0x00-0x0F : byte[7:4]
  localparam logic [4:0] CMD_COL_HI = 5'b00010; // 0x10-0x17 : byte[7:3]
  localparam logic [4:0] CMD_PAGE   = 5'b10110; // 0xB0-0xB7 : byte[7:3]

endpackage

// File: rtl/link_sync.sv
// Multi-flop synchroniser for one asynchronous link line. It also provides
// registered one-cycle rise/fall pulses. level_o is the delayed level that
// lines up in time with those pulses.
module link_sync #(
  parameter int   STAGES = 2,
  parameter logic IDLE   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Synchronise the input and register its edge pulses; reset goes to the idle level.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= {STAGES{IDLE}};
      prev_q <= IDLE;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/oled_spi_receiver.sv
// Display serial link receiver. It oversamples SCLK/nCS/DnC/SDIN,
// assembles MSB-first bytes and turns data bytes into frame-buffer writes
// with an auto-incrementing page/column address.
// Optional feature: define OLED_ADDR_CMD_EN to let command bytes
// 0x00-0x0F, 0x10-0x17 and 0xB0-0xB7 set the column and page address.
module oled_spi_receiver
  import display_pkg::*;
#(
  parameter int COLS        = DEF_COLS,
  parameter int PAGES       = DEF_PAGES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       Clock,
  input  logic                       nReset,
  input  logic                       SCLK,
  input  logic                       nCS,
  input  logic                       DnC,
  input  logic                       SDIN,
  output logic                       ByteValid,
  output logic [7:0]                 ByteData,
  output logic                       ByteIsData,
  output logic                       WrEn,
  output logic [$clog2(PAGES)-1:0]   WrPage,
  output logic [$clog2(COLS)-1:0]    WrCol,
  output logic [7:0]                 WrData,
  output logic                       FrameErr
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ncs_level, ncs_rise, ncs_fall;

  link_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_sclk (
    .clk_i   (Clock),
    .rst_n_i (nReset),
    .d_i     (SCLK),
    .level_o (sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  link_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_ncs (
    .clk_i   (Clock),
    .rst_n_i (nReset),
    .d_i     (nCS),
    .level_o (ncs_level),
    .rise_o  (ncs_rise),
    .fall_o  (ncs_fall)
  );

  logic [SYNC_STAGES-1:0] sdin_sync_q;
  logic [SYNC_STAGES-1:0] dnc_sync_q;

  // Plain synchronisers for the data lines. They hold steady for several
  // cycles around each SCLK rise, so no extra alignment flop is needed.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      sdin_sync_q <= '0;
      dnc_sync_q  <= '0;
    end else begin
      sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], SDIN};
      dnc_sync_q  <= {dnc_sync_q[SYNC_STAGES-2:0], DnC};
    end
  end

  logic sdin_s, dnc_s;
  assign sdin_s = sdin_sync_q[SYNC_STAGES-1];
  assign dnc_s  = dnc_sync_q[SYNC_STAGES-1];

  // Only 7 bits are kept: the eighth bit goes straight into the byte register.
  logic [6:0]    sr_q, sr_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic          byte_is_data_q, byte_is_data_d;
  logic          wr_en_q, wr_en_d;
  logic          frame_err_q, frame_err_d;
  logic [PW-1:0] page_q, page_d;
  logic [CW-1:0] col_q, col_d;
  logic          shift_en, byte_done;

  // Register all receiver state.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      sr_q           <= '0;
      bitcnt_q       <= '0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= '0;
      byte_is_data_q <= 1'b0;
      wr_en_q        <= 1'b0;
      frame_err_q    <= 1'b0;
      page_q         <= '0;
      col_q          <= '0;
    end else begin
      sr_q           <= sr_d;
      bitcnt_q       <= bitcnt_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      wr_en_q        <= wr_en_d;
      frame_err_q    <= frame_err_d;
      page_q         <= page_d;
      col_q          <= col_d;
    end
  end

  // Shift, byte completion, framing error and address update.
  always_comb begin
    sr_d           = sr_q;
    bitcnt_d       = bitcnt_q;
    byte_valid_d   = 1'b0;
    byte_data_d    = byte_data_q;
    byte_is_data_d = byte_is_data_q;
    wr_en_d        = 1'b0;
    frame_err_d    = 1'b0;
    page_d         = page_q;
    col_d          = col_q;

    // A rise that coincides with the nCS rise still belongs to the frame,
    // so a final bit arriving together with the deselect completes its byte.
    shift_en  = sclk_rise && (!ncs_level || ncs_rise);
    byte_done = shift_en && (bitcnt_q == 3'd7);

    if (ncs_fall) begin
      bitcnt_d = '0;
    end else if (shift_en) begin
      sr_d     = {sr_q[5:0], sdin_s};
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        byte_valid_d   = 1'b1;
        byte_data_d    = {sr_q, sdin_s};
        byte_is_data_d = dnc_s;
        wr_en_d        = dnc_s;
      end
    end

    if (ncs_rise && !byte_done) begin
      bitcnt_d    = '0;
      frame_err_d = (bitcnt_q != 3'd0) || shift_en;
    end

    // The address advances one cycle after the write strobe, so WrPage/WrCol
    // show the pre-increment address while WrEn is high.
    if (wr_en_q) begin
      if (col_q == CW'(COLS - 1)) begin
        col_d  = '0;
        page_d = (page_q == PW'(PAGES - 1)) ? '0 : page_q + PW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
`ifdef OLED_ADDR_CMD_EN
    else if (byte_valid_q && !byte_is_data_q) begin
      if (byte_data_q[7:4] == CMD_COL_LO) begin
        col_d[3:0] = byte_data_q[3:0];
      end else if (byte_data_q[7:3] == CMD_COL_HI) begin
        col_d[6:4] = byte_data_q[2:0];
      end else if (byte_data_q[7:3] == CMD_PAGE) begin
        page_d = PW'(byte_data_q[2:0]);
      end
    end
`endif
  end

  assign ByteValid  = byte_valid_q;
  assign ByteData   = byte_data_q;
  assign ByteIsData = byte_is_data_q;
  assign WrEn       = wr_en_q;
  assign WrPage     = page_q;
  assign WrCol      = col_q;
  assign WrData     = byte_data_q;
  assign FrameErr   = frame_err_q;

endmodule
